ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single sp_ram port. Each accepted request's
// master index goes into an in-order ID FIFO so responses can be routed back.
module ram_arbiter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    port_req_o,
    output logic [ADDR_WIDTH-1:0]   port_addr_o,
    output logic                    port_we_o,
    output logic [DATA_WIDTH-1:0]   port_wdata_o,
    output logic [DATA_WIDTH/8-1:0] port_be_o,
    input  logic                    port_gnt_i,
    input  logic                    port_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   port_rdata_i
);

    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [1:0]       LAST_PTR = 2'(MAX_OUTSTANDING - 1);

    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [3:0]       r_ids;
    logic             r_rr;

    logic w_any_req;
    logic w_allowed;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_head;

    // A full FIFO may still accept when a response frees a slot in the same cycle.
    always_comb begin
        w_any_req = m0_req_i | m1_req_i;
        w_allowed = (r_count < MAX_CNT) || ((r_count == MAX_CNT) && port_rvalid_i);
        w_sel     = (m0_req_i & m1_req_i) ? r_rr : m1_req_i;
        w_pop     = port_rvalid_i & (r_count != '0);
        w_head    = r_ids[r_rptr];
    end

    assign port_req_o   = rst_n & w_any_req & w_allowed;
    assign port_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
    assign port_we_o    = w_sel ? m1_we_i    : m0_we_i;
    assign port_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;
    assign port_be_o    = w_sel ? m1_be_i    : m0_be_i;

    assign w_push   = port_req_o & port_gnt_i;
    assign m0_gnt_o = w_push & ~w_sel;
    assign m1_gnt_o = w_push &  w_sel;

    assign m0_rvalid_o = w_pop & ~w_head;
    assign m1_rvalid_o = w_pop &  w_head;
    assign m0_rdata_o  = m0_rvalid_o ? port_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? port_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ids   <= '0;
            r_rr    <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= w_sel;
                r_wptr        <= (r_wptr == LAST_PTR) ? 2'd0 : r_wptr + 2'd1;
                r_rr          <= ~w_sel;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? 2'd0 : r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a one-cycle-latency RAM model that can be
// overridden by hand-driven responses, with hand-computed expectations.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;

    logic        port_req_o, port_we_o;
    logic [7:0]  port_addr_o;
    logic [31:0] port_wdata_o;
    logic [3:0]  port_be_o;
    logic        port_gnt_i, port_rvalid_i;
    logic [31:0] port_rdata_i;

    logic        gnt_en, manual, man_rv;
    logic [31:0] man_rd;
    logic        ram_rv;
    logic [31:0] ram_rd;
    logic [31:0] mem [256];

    int n_checks;
    int n_fail;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .port_req_o(port_req_o), .port_addr_o(port_addr_o), .port_we_o(port_we_o),
        .port_wdata_o(port_wdata_o), .port_be_o(port_be_o),
        .port_gnt_i(port_gnt_i), .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign port_gnt_i    = gnt_en;
    assign port_rvalid_i = manual ? man_rv : ram_rv;
    assign port_rdata_i  = manual ? man_rd : ram_rd;

    // RAM model: one response per accepted request, one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h80] <= 32'hCAFE0080;
            mem[8'h81] <= 32'h11110081;
        end
        ram_rv <= port_req_o & port_gnt_i;
        ram_rd <= mem[port_addr_o];
        if (port_req_o & port_gnt_i & port_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (port_be_o[b]) mem[port_addr_o][8*b +: 8] <= port_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m0_req = 1'b1; m0_addr = 8'h80; m0_we = 1'b0; m0_wdata = '0; m0_be = 4'hF;
        m1_req = 1'b0; m1_addr = 8'h00; m1_we = 1'b0; m1_wdata = '0; m1_be = 4'hF;
        gnt_en = 1'b1; manual = 1'b0; man_rv = 1'b0; man_rd = '0;
        #2;
        check("rst_port_req", port_req_o, 0);
        check("rst_m0_gnt", m0_gnt_o, 0);
        check("rst_m0_rvalid", m0_rvalid_o, 0);
        check("rst_m1_rvalid", m1_rvalid_o, 0);
        check("rst_m0_rdata", m0_rdata_o, 0);
        tick; tick;
        m0_req = 1'b0;
        rst_n  = 1'b1;

        // single read from m0
        tick;
        m0_req = 1'b1; m0_addr = 8'h80;
        #1;
        check("rd_m0_gnt", m0_gnt_o, 1);
        check("rd_m1_gnt", m1_gnt_o, 0);
        check("rd_port_addr", port_addr_o, 32'h80);
        tick;
        m0_req = 1'b0;
        #1;
        check("rd_m0_rvalid", m0_rvalid_o, 1);
        check("rd_m0_rdata", m0_rdata_o, 32'hCAFE0080);
        check("rd_m1_rvalid", m1_rvalid_o, 0);
        check("rd_m1_rdata", m1_rdata_o, 0);
        tick;

        // both masters request continuously after reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        m0_req = 1'b1; m0_addr = 8'h80;
        m1_req = 1'b1; m1_addr = 8'h81;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_m0_gnt", m0_gnt_o, (i % 2 == 0));
            check("rr_m1_gnt", m1_gnt_o, (i % 2 == 1));
            check("rr_m0_rvalid", m0_rvalid_o, (i > 0) && ((i - 1) % 2 == 0));
            check("rr_m1_rvalid", m1_rvalid_o, (i > 0) && ((i - 1) % 2 == 1));
            if (i > 0) begin
                check("rr_rdata", ((i - 1) % 2 == 1) ? m1_rdata_o : m0_rdata_o,
                      ((i - 1) % 2 == 1) ? 32'h11110081 : 32'hCAFE0080);
            end
            tick;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        check("rr_last_m1_rvalid", m1_rvalid_o, 1);
        check("rr_last_m1_rdata", m1_rdata_o, 32'h11110081);
        check("rr_last_m0_rvalid", m0_rvalid_o, 0);
        tick;

        // m1 writes, m0 reads back
        m1_req = 1'b1; m1_addr = 8'hCC; m1_we = 1'b1; m1_wdata = 32'h0000BEEF; m1_be = 4'b1111;
        #1;
        check("wr_m1_gnt", m1_gnt_o, 1);
        check("wr_port_we", port_we_o, 1);
        tick;
        m1_req = 1'b0; m1_we = 1'b0;
        m0_req = 1'b1; m0_addr = 8'hCC; m0_we = 1'b0;
        #1;
        check("wr_m1_ack", m1_rvalid_o, 1);
        check("wb_m0_gnt", m0_gnt_o, 1);
        tick;
        m0_req = 1'b0;
        #1;
        check("wb_m0_rvalid", m0_rvalid_o, 1);
        check("wb_m0_rdata", m0_rdata_o, 32'h0000BEEF);
        check("wb_m1_rvalid", m1_rvalid_o, 0);
        tick;

        // outstanding limit with responses withheld
        manual = 1'b1; man_rv = 1'b0;
        m0_req = 1'b1; m0_addr = 8'h10;
        #1;
        check("lim_gnt1", m0_gnt_o, 1);
        tick;
        #1;
        check("lim_gnt2", m0_gnt_o, 1);
        tick;
        #1;
        check("lim_blk_req", port_req_o, 0);
        check("lim_blk_gnt", m0_gnt_o, 0);
        tick;
        #1;
        check("lim_blk_req2", port_req_o, 0);
        tick;
        man_rv = 1'b1; man_rd = 32'hA5A50001;
        #1;
        check("lim_free_req", port_req_o, 1);
        check("lim_free_gnt", m0_gnt_o, 1);
        check("lim_m0_rvalid", m0_rvalid_o, 1);
        check("lim_m0_rdata", m0_rdata_o, 32'hA5A50001);
        check("lim_m1_rvalid", m1_rvalid_o, 0);
        tick;
        m0_req = 1'b0; man_rv = 1'b0;

        // reset with two outstanding, then a stray response
        rst_n = 1'b0; man_rv = 1'b1; man_rd = 32'hDEAD0001;
        #1;
        check("prst_m0_rvalid", m0_rvalid_o, 0);
        check("prst_m1_rvalid", m1_rvalid_o, 0);
        check("prst_m0_rdata", m0_rdata_o, 0);
        tick;
        rst_n = 1'b1;
        #1;
        check("spur_m0_rvalid", m0_rvalid_o, 0);
        check("spur_m1_rvalid", m1_rvalid_o, 0);
        check("spur_m1_rdata", m1_rdata_o, 0);
        tick;
        man_rv = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        check("post_m0_gnt", m0_gnt_o, 1);
        check("post_m1_gnt", m1_gnt_o, 0);
        tick;
        #1;
        check("post_m1_gnt2", m1_gnt_o, 1);
        check("post_m0_gnt2", m0_gnt_o, 0);
        tick;
        #1;
        check("post_full_req", port_req_o, 0);
        m0_req = 1'b0; m1_req = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
